// File: rtl/tt_lq_tracker_if.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tt_briscv_pkg / tt_lq_tracker_if                           |
// | Description : Shared load-queue types and the bundled dispatch,          |
// |               completion, retire and status signals of tt_lq_tracker.    |
// |               master : driven by the dispatch/memory/retire side         |
// |               slave  : the tracker itself                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package tt_briscv_pkg;
  localparam int LQ_DEPTH = 8;

  // Per-entry record stored at dispatch and returned at retire.
  typedef struct packed {
    logic       load;        // scalar load, waits for a memory return
    logic       vec_load;    // vector load, waits for a memory return
    logic       vl_is_zero;  // vector op with vl==0, no memory access
    logic [4:0] rd;          // destination register
    logic [1:0] size;        // access size
  } lq_info_s;
endpackage

interface tt_lq_tracker_if #(
  parameter int LQ_DEPTH      = tt_briscv_pkg::LQ_DEPTH,
  parameter int LQ_DEPTH_LOG2 = $clog2(LQ_DEPTH)
);
  // Dispatch / allocation
  logic                         i_alloc_vld;
  tt_briscv_pkg::lq_info_s      i_alloc_info;
  logic                         o_alloc_rdy;
  logic [LQ_DEPTH_LOG2-1:0]     o_alloc_id;
  // Memory completion
  logic                         i_cmpl_vld;
  logic [LQ_DEPTH_LOG2-1:0]     i_cmpl_id;
  // Retire
  logic                         o_retire_vld;
  logic [LQ_DEPTH_LOG2-1:0]     o_retire_id;
  tt_briscv_pkg::lq_info_s      o_retire_info;
  logic                         i_retire_rdy;
  // Control / status
  logic                         i_flush;
  logic [LQ_DEPTH_LOG2:0]       o_count;
  logic                         o_empty;
  logic                         o_full;
  logic                         o_cmpl_err;

  modport master (
    output i_alloc_vld, i_alloc_info, i_cmpl_vld, i_cmpl_id, i_retire_rdy, i_flush,
    input  o_alloc_rdy, o_alloc_id, o_retire_vld, o_retire_id, o_retire_info,
    input  o_count, o_empty, o_full, o_cmpl_err
  );

  modport slave (
    input  i_alloc_vld, i_alloc_info, i_cmpl_vld, i_cmpl_id, i_retire_rdy, i_flush,
    output o_alloc_rdy, o_alloc_id, o_retire_vld, o_retire_id, o_retire_info,
    output o_count, o_empty, o_full, o_cmpl_err
  );
endinterface

`default_nettype wire

// File: rtl/tt_lq_tracker.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tt_lq_tracker                                              |
// | Description : In-order load-queue scheduler. Allocates ids at dispatch,  |
// |               accepts out-of-order completions by id and retires entries |
// |               strictly in allocation order.                              |
// | Ports       : i_clk   - clock                                            |
// |               i_reset - synchronous active-high reset                    |
// |               lq      - slave side of tt_lq_tracker_if (alloc, cmpl,     |
// |                         retire, flush and status signals)                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tt_lq_tracker #(
  parameter int LQ_DEPTH      = tt_briscv_pkg::LQ_DEPTH,
  parameter int LQ_DEPTH_LOG2 = $clog2(LQ_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  tt_lq_tracker_if.slave     lq
);
  import tt_briscv_pkg::lq_info_s;

  localparam int                     C_CW    = LQ_DEPTH_LOG2 + 1;
  localparam logic [C_CW-1:0]        C_DEPTH = C_CW'(LQ_DEPTH);

  // Entry state
  logic [LQ_DEPTH-1:0]       valid_q, valid_d;
  logic [LQ_DEPTH-1:0]       done_q,  done_d;
  lq_info_s                  info_q [LQ_DEPTH];
  lq_info_s                  info_d [LQ_DEPTH];
  // Pointers wrap naturally because LQ_DEPTH is a power of two
  logic [LQ_DEPTH_LOG2-1:0]  head_q, head_d;
  logic [LQ_DEPTH_LOG2-1:0]  tail_q, tail_d;
  logic [C_CW-1:0]           count_q, count_d;
  logic                      err_q, err_d;

  logic                      w_full;
  logic                      w_retire_vld;
  logic                      w_alloc_fire;
  logic                      w_retire_fire;
  logic                      w_alloc_done;

  always_comb begin
    // Readiness comes from the registered count only, so a retire in the
    // same cycle never frees a slot for an alloc.
    w_full        = (count_q == C_DEPTH);
    w_retire_vld  = valid_q[head_q] & done_q[head_q];
    w_alloc_fire  = lq.i_alloc_vld & ~w_full & ~lq.i_flush;
    w_retire_fire = w_retire_vld & lq.i_retire_rdy & ~lq.i_flush;
    // Entries that never see a memory return are complete at dispatch.
    w_alloc_done  = (~lq.i_alloc_info.load & ~lq.i_alloc_info.vec_load)
                    | lq.i_alloc_info.vl_is_zero;

    valid_d = valid_q;
    done_d  = done_q;
    info_d  = info_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;

    if (lq.i_flush) begin
      // Info storage is left as-is: it is qualified by valid everywhere.
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // A completion racing the allocation of its own slot is illegal; the
      // slot is still invalid in the registered state so this falls out of
      // the valid check, the explicit term only documents the intent.
      if (lq.i_cmpl_vld) begin
        if (valid_q[lq.i_cmpl_id] && !done_q[lq.i_cmpl_id] &&
            !(w_alloc_fire && (lq.i_cmpl_id == tail_q))) begin
          done_d[lq.i_cmpl_id] = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      // head==tail only when empty (no retire) or full (no alloc), so the
      // retire and alloc updates never touch the same slot.
      if (w_retire_fire) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + 1'b1;
      end

      if (w_alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = w_alloc_done;
        info_d[tail_q]  = lq.i_alloc_info;
        tail_d          = tail_q + 1'b1;
      end

      count_d = count_q + C_CW'(w_alloc_fire) - C_CW'(w_retire_fire);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= '0;
      done_q  <= '0;
      info_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      info_q  <= info_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign lq.o_alloc_rdy   = ~w_full;
  assign lq.o_alloc_id    = tail_q;
  assign lq.o_retire_vld  = w_retire_vld;
  assign lq.o_retire_id   = head_q;
  assign lq.o_retire_info = info_q[head_q];
  assign lq.o_count       = count_q;
  assign lq.o_empty       = (count_q == '0);
  assign lq.o_full        = w_full;
  assign lq.o_cmpl_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_lq_tracker.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_tt_lq_tracker                                           |
// | Description : Directed self-checking bench for tt_lq_tracker: a vector   |
// |               table for single-cycle behaviour plus hand-written         |
// |               multi-cycle sequences.                                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_tt_lq_tracker;
  import tt_briscv_pkg::lq_info_s;

  localparam int DEPTH = 8;
  localparam int LOG2  = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  tt_lq_tracker_if #(.LQ_DEPTH(DEPTH), .LQ_DEPTH_LOG2(LOG2)) bus ();

  tt_lq_tracker #(.LQ_DEPTH(DEPTH), .LQ_DEPTH_LOG2(LOG2)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .lq      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Occupancy must never leave 0..DEPTH (underflow wraps to a large value).
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (int'(bus.o_count) > DEPTH) begin
        failures++;
        $display("FAIL count_range: o_count=%0d required<=%0d", bus.o_count, DEPTH);
      end
    end
  end

  typedef struct {
    logic       a;       // alloc_vld
    logic       ld;      // info.load
    logic       vl;      // info.vec_load
    logic       z;       // info.vl_is_zero
    logic       c;       // cmpl_vld
    logic [2:0] cid;     // cmpl_id
    logic       r;       // retire_rdy
    logic       f;       // flush
    logic       e_rvld;  // expected after the edge
    logic [2:0] e_rid;
    logic [3:0] e_cnt;
    logic [2:0] e_aid;
    logic       e_err;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic lq_info_s mk(input logic ld, input logic vl, input logic z,
                                  input logic [4:0] rd);
    lq_info_s v;
    v            = '0;
    v.load       = ld;
    v.vec_load   = vl;
    v.vl_is_zero = z;
    v.rd         = rd;
    return v;
  endfunction

  task automatic idle();
    bus.i_alloc_vld  = 1'b0;
    bus.i_alloc_info = '0;
    bus.i_cmpl_vld   = 1'b0;
    bus.i_cmpl_id    = '0;
    bus.i_retire_rdy = 1'b0;
    bus.i_flush      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_alloc_rdy"},   int'(bus.o_alloc_rdy),   1);
    chk({tag, "_alloc_id"},    int'(bus.o_alloc_id),    0);
    chk({tag, "_retire_vld"},  int'(bus.o_retire_vld),  0);
    chk({tag, "_retire_id"},   int'(bus.o_retire_id),   0);
    chk({tag, "_retire_info"}, int'(bus.o_retire_info), 0);
    chk({tag, "_count"},       int'(bus.o_count),       0);
    chk({tag, "_empty"},       int'(bus.o_empty),       1);
    chk({tag, "_full"},        int'(bus.o_full),        0);
    chk({tag, "_err"},         int'(bus.o_cmpl_err),    0);
  endtask

  task automatic alloc_one(input logic ld, input logic vl, input logic z,
                           input logic [4:0] rd);
    bus.i_alloc_vld  = 1'b1;
    bus.i_alloc_info = mk(ld, vl, z, rd);
    tick();
    bus.i_alloc_vld  = 1'b0;
  endtask

  task automatic cmpl_one(input logic [2:0] id);
    bus.i_cmpl_vld = 1'b1;
    bus.i_cmpl_id  = id;
    tick();
    bus.i_cmpl_vld = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();

    // a  ld vl z  c cid r f  rvld rid cnt aid err
    vt[0]  = '{1,1,0,0, 0,0, 0,0, 0,0,1,1,0};
    vt[1]  = '{1,1,0,0, 0,0, 0,0, 0,0,2,2,0};
    vt[2]  = '{1,1,0,0, 0,0, 0,0, 0,0,3,3,0};
    vt[3]  = '{0,0,0,0, 1,2, 0,0, 0,0,3,3,0};   // complete 2: head still pending
    vt[4]  = '{0,0,0,0, 1,1, 0,0, 0,0,3,3,0};   // complete 1: head still pending
    vt[5]  = '{0,0,0,0, 1,0, 0,0, 1,0,3,3,0};   // complete 0: head retireable
    vt[6]  = '{0,0,0,0, 0,0, 1,0, 1,1,2,3,0};
    vt[7]  = '{0,0,0,0, 0,0, 1,0, 1,2,1,3,0};
    vt[8]  = '{0,0,0,0, 0,0, 1,0, 0,3,0,3,0};
    vt[9]  = '{1,0,0,0, 0,0, 0,0, 1,3,1,4,0};   // store: done at alloc
    vt[10] = '{1,0,1,1, 0,0, 1,0, 1,4,1,5,0};   // vec_load vl=0 while store retires
    vt[11] = '{0,0,0,0, 1,4, 0,0, 1,4,1,5,1};   // completion to a done entry
    vt[12] = '{0,0,0,0, 0,0, 1,0, 0,5,0,5,1};

    do_reset();
    chk_reset_vals("rst0");

    for (int i = 0; i < 13; i++) begin
      bus.i_alloc_vld  = vt[i].a;
      bus.i_alloc_info = mk(vt[i].ld, vt[i].vl, vt[i].z, 5'(i));
      bus.i_cmpl_vld   = vt[i].c;
      bus.i_cmpl_id    = vt[i].cid;
      bus.i_retire_rdy = vt[i].r;
      bus.i_flush      = vt[i].f;
      tick();
      chk($sformatf("v%0d_rvld", i),  int'(bus.o_retire_vld), int'(vt[i].e_rvld));
      chk($sformatf("v%0d_rid", i),   int'(bus.o_retire_id),  int'(vt[i].e_rid));
      chk($sformatf("v%0d_count", i), int'(bus.o_count),      int'(vt[i].e_cnt));
      chk($sformatf("v%0d_aid", i),   int'(bus.o_alloc_id),   int'(vt[i].e_aid));
      chk($sformatf("v%0d_err", i),   int'(bus.o_cmpl_err),   int'(vt[i].e_err));
    end
    idle();

    // Fill and drain
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill%0d_aid", i), int'(bus.o_alloc_id), i);
      alloc_one(1'b1, 1'b0, 1'b0, 5'(i + 8));
    end
    chk("fill_full",      int'(bus.o_full),      1);
    chk("fill_alloc_rdy", int'(bus.o_alloc_rdy), 0);
    chk("fill_count",     int'(bus.o_count),     8);
    alloc_one(1'b1, 1'b0, 1'b0, 5'd0);
    chk("fill_overflow_count", int'(bus.o_count), 8);
    for (int i = 0; i < 8; i++) cmpl_one(3'(i));
    chk("fill_err", int'(bus.o_cmpl_err), 0);
    bus.i_retire_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_vld", i),  int'(bus.o_retire_vld),     1);
      chk($sformatf("drain%0d_id", i),   int'(bus.o_retire_id),      i);
      chk($sformatf("drain%0d_rd", i),   int'(bus.o_retire_info.rd), i + 8);
      tick();
    end
    bus.i_retire_rdy = 1'b0;
    chk("drain_empty", int'(bus.o_empty),      1);
    chk("drain_rvld",  int'(bus.o_retire_vld), 0);

    // Wrap: full queue with head at id 3, retire while alloc is requested
    do_reset();
    for (int i = 0; i < 8; i++) alloc_one(1'b1, 1'b0, 1'b0, 5'(i));
    for (int i = 0; i < 4; i++) cmpl_one(3'(i));
    bus.i_retire_rdy = 1'b1;
    tick(); tick(); tick();
    bus.i_retire_rdy = 1'b0;
    for (int i = 0; i < 3; i++) alloc_one(1'b1, 1'b0, 1'b0, 5'(i + 16));
    chk("wrap_count8", int'(bus.o_count),     8);
    chk("wrap_rid",    int'(bus.o_retire_id), 3);
    bus.i_retire_rdy = 1'b1;
    bus.i_alloc_vld  = 1'b1;
    bus.i_alloc_info = mk(1'b1, 1'b0, 1'b0, 5'd30);
    tick();
    chk("wrap_count7", int'(bus.o_count),    7);
    chk("wrap_aid",    int'(bus.o_alloc_id), 3);
    bus.i_retire_rdy = 1'b0;
    tick();
    bus.i_alloc_vld  = 1'b0;
    chk("wrap_refill_count", int'(bus.o_count), 8);
    chk("wrap_refill_aid",   int'(bus.o_alloc_id), 4);

    // Simultaneous alloc and retire at count=4
    do_reset();
    for (int i = 0; i < 4; i++) alloc_one(1'b0, 1'b0, 1'b0, 5'(i));
    chk("sim_count_pre", int'(bus.o_count), 4);
    bus.i_alloc_vld  = 1'b1;
    bus.i_alloc_info = mk(1'b0, 1'b0, 1'b0, 5'd9);
    bus.i_retire_rdy = 1'b1;
    tick();
    idle();
    chk("sim_count", int'(bus.o_count),     4);
    chk("sim_rid",   int'(bus.o_retire_id), 1);
    chk("sim_aid",   int'(bus.o_alloc_id),  5);

    // Illegal completion, then flush mid-operation
    do_reset();
    cmpl_one(3'd5);
    chk("ill_err",   int'(bus.o_cmpl_err),   1);
    chk("ill_count", int'(bus.o_count),      0);
    chk("ill_rvld",  int'(bus.o_retire_vld), 0);
    chk("ill_aid",   int'(bus.o_alloc_id),   0);
    for (int i = 0; i < 5; i++) alloc_one(1'b1, 1'b0, 1'b0, 5'(i));
    cmpl_one(3'd0);
    cmpl_one(3'd1);
    chk("pre_flush_rvld",  int'(bus.o_retire_vld), 1);
    chk("pre_flush_count", int'(bus.o_count),      5);
    bus.i_flush      = 1'b1;
    bus.i_alloc_vld  = 1'b1;
    bus.i_alloc_info = mk(1'b1, 1'b0, 1'b0, 5'd7);
    bus.i_cmpl_vld   = 1'b1;
    bus.i_cmpl_id    = 3'd2;
    bus.i_retire_rdy = 1'b1;
    tick();
    idle();
    chk("flush_count", int'(bus.o_count),      0);
    chk("flush_rvld",  int'(bus.o_retire_vld), 0);
    chk("flush_empty", int'(bus.o_empty),      1);
    chk("flush_aid",   int'(bus.o_alloc_id),   0);
    chk("flush_err",   int'(bus.o_cmpl_err),   1);
    alloc_one(1'b1, 1'b0, 1'b0, 5'd3);
    chk("post_flush_count", int'(bus.o_count),      1);
    chk("post_flush_rvld",  int'(bus.o_retire_vld), 0);
    chk("post_flush_aid",   int'(bus.o_alloc_id),   1);

    // Reset clears everything including the sticky error
    do_reset();
    chk_reset_vals("rst1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tt_lq_tracker.md
# tt_lq_tracker

In-order load-queue scheduler for the scalar/vector memory pipe. It allocates `ldqid`s to instructions at dispatch and holds each entry's `lq_info_s` record. It accepts out-of-order memory completions by id and releases entries strictly in allocation order to the writeback/retire stage. It owns the LQ_DEPTH entry pool that `mem_skidbuf_s.mem_lqid` and `vec_autogen_s.ldqid` index into.

## Interface
- `LQ_DEPTH`, default `tt_briscv_pkg::LQ_DEPTH` (8): number of entries. Must be a power of 2 in the range 2..16.
- `LQ_DEPTH_LOG2`, default `$clog2(LQ_DEPTH)`: width of an entry id.

Ports:
- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_alloc_vld`  in  1  dispatch requests an entry.
- `i_alloc_info`  in  `lq_info_s`  record stored into the entry.
- `o_alloc_rdy`  out  1  an entry is free.
- `o_alloc_id`  out  LQ_DEPTH_LOG2  id granted when alloc fires (the tail pointer).
- `i_cmpl_vld`  in  1  memory returns a completion.
- `i_cmpl_id`  in  LQ_DEPTH_LOG2  id being completed.
- `o_retire_vld`  out  1  the head entry is valid and done.
- `o_retire_id`  out  LQ_DEPTH_LOG2  head pointer.
- `o_retire_info`  out  `lq_info_s`  head entry record.
- `i_retire_rdy`  in  1  consumer accepts the head entry.
- `i_flush`  in  1  drops all entries.
- `o_count`  out  LQ_DEPTH_LOG2+1  number of occupied entries.
- `o_empty`  out  1  asserted when `o_count` == 0.
- `o_full`  out  1  asserted when `o_count` == LQ_DEPTH.
- `o_cmpl_err`  out  1  sticky: a completion was illegal.

## Operation
- State:
  - per entry: `valid`, `done`, and `info`;
  - `head` and `tail` pointers, LQ_DEPTH_LOG2 bits each, wrapping naturally;
  - `count`, LQ_DEPTH_LOG2+1 bits;
  - `err` flag.
- Alloc fire = `i_alloc_vld & o_alloc_rdy`, where `o_alloc_rdy = !o_full`.
  - No same-cycle bypass: a retire does not free a slot for an alloc in the same cycle.
- On alloc fire, the entry at `tail` is written with `valid=1` and `info=i_alloc_info`, and `tail` increments.
  - `done` is set at alloc when `info.load==0 && info.vec_load==0`, or when `info.vl_is_zero==1`. These entries need no memory return.
  - Otherwise `done=0`.
- Completion (`i_cmpl_vld`):
  - If the target entry is valid and not done, set its `done`.
  - Otherwise set `err`, and no entry state changes.
  - A completion targeting the entry being allocated in the same cycle counts as an error.
- Retire fire = `o_retire_vld & i_retire_rdy`, where `o_retire_vld = valid[head] & done[head]`.
  - On fire, clear `valid[head]` and `done[head]`, then increment `head`.
  - Only the head entry can retire. Completed younger entries wait behind an incomplete head.
- `count_next = count + alloc_fire - retire_fire`.
  - Simultaneous alloc and retire leaves `count` unchanged.
  - The design must not underflow or overflow the count; a bench assertion checks this.
- `i_flush` has priority over alloc, completion and retire in the same cycle.
  - It clears all `valid` and `done` bits and sets `head=tail=count=0`.
  - It suppresses alloc fire, retire fire and error detection in that cycle.
  - It does not clear `err`.
- `i_reset` clears everything, including `err`.

## Timing
- Reset values of outputs:
  - `o_alloc_rdy=1`, `o_alloc_id=0`;
  - `o_retire_vld=0`, `o_retire_id=0`, `o_retire_info=0` (info storage is reset to 0);
  - `o_count=0`, `o_empty=1`, `o_full=0`, `o_cmpl_err=0`.
- All outputs are driven directly from registers or from a head-indexed mux of registers. No input-to-output combinational path exists: `o_alloc_rdy` does not depend on `i_retire_rdy`.
- Alloc fire at cycle N:
  - the entry is visible in `o_count` at N+1;
  - an alloc-done entry at the head gives `o_retire_vld` at N+1.
- Completion at cycle N for the head entry gives `o_retire_vld=1` at N+1.
- Back-to-back retires are sustained at 1 per cycle while the head entries are done.
- `i_flush` at cycle N: the queue is empty at N+1, and alloc is accepted again from N+1 with `o_alloc_id=0`.
- `o_cmpl_err` rises at N+1 after an illegal completion at N.

## Test plan
- **Fill and drain:** 8 back-to-back allocs of loads → ids 0..7; `o_full=1` after the 8th and `o_alloc_rdy=0`. Complete ids 0..7, then hold `i_retire_rdy=1` → 8 retires on consecutive cycles with ids 0..7; `o_empty=1` afterwards.
- **Out-of-order completion:** alloc ids 0,1,2 (loads). Complete 2, then 1 → `o_retire_vld` stays 0. Complete 0 → retires 0,1,2 on consecutive cycles.
- **Non-load and vl=0 entries:** alloc a store (`load=0`) and then a vec_load with `vl_is_zero=1` → both retire on the cycle after alloc with no completion; a completion to either sets `o_cmpl_err`.
- **Wrap and simultaneous events:**
  - With count=8, retire head id 3 while `i_alloc_vld=1` → alloc is not accepted and count becomes 7. Next cycle, alloc gets id 3.
  - At count=4, simultaneous alloc and retire → count stays 4.
- **Flush mid-operation:** 5 entries, 2 of them done, then assert `i_flush` together with alloc, cmpl and retire → next cycle count=0 and `o_retire_vld=0`; the next alloc gets id 0; the earlier-set `o_cmpl_err` remains 1.
- **Illegal completion and reset:** complete id 5 while it is not valid → `o_cmpl_err=1` at N+1 and no state change. Assert `i_reset` → all outputs return to their reset values, with `o_cmpl_err=0`.
